// File: rtl/resp_sig_pkg.sv
// rtl/resp_sig_pkg.sv - shared types and defaults for the response signature capture block
package resp_sig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam int          DEF_SIG_W = 32;
  localparam logic [31:0] DEF_POLY  = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SEED  = 32'hFFFF_FFFF;

endpackage

// File: rtl/resp_misr_step.sv
// rtl/resp_misr_step.sv - one MISR step: fold the response bus into SIG_W bits, then shift with feedback
module resp_misr_step
  import resp_sig_pkg::*;
#(
  parameter int               DATA_W = 245,
  parameter int               SIG_W  = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY   = DEF_POLY
) (
  input  logic [SIG_W-1:0]  sig_i,
  input  logic [DATA_W-1:0] y_i,
  output logic [SIG_W-1:0]  sig_o
);

  localparam int NSLICE = (DATA_W + SIG_W - 1) / SIG_W;

  logic [NSLICE*SIG_W-1:0] y_ext;
  logic [SIG_W-1:0]        fold;

  always_comb begin
    // Zero-extend so the top slice is padded rather than truncated.
    y_ext              = '0;
    y_ext[DATA_W-1:0]  = y_i;
    fold               = '0;
    for (int k = 0; k < NSLICE; k++) begin
      fold = fold ^ y_ext[k*SIG_W +: SIG_W];
    end
    sig_o = {sig_i[SIG_W-2:0], 1'b0} ^ (sig_i[SIG_W-1] ? POLY : '0) ^ fold;
  end

endmodule

// File: rtl/resp_sig_capture.sv
// rtl/resp_sig_capture.sv - compacts a run of response vectors into a MISR signature and checks it
module resp_sig_capture
  import resp_sig_pkg::*;
#(
  parameter int               DATA_W = 245,
  parameter int               SIG_W  = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED   = DEF_SEED,
  parameter int               CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [SIG_W-1:0]  exp_sig,
  input  logic              y_valid,
  input  logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  vec_count
);

  state_e             state_q, state_d;
  logic [SIG_W-1:0]   sig_q, sig_d, step_sig;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [SIG_W-1:0]   exp_q, exp_d;
  logic               pass_q, pass_d;
  logic               done_q, done_d;

  resp_misr_step #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY)
  ) u_step (
    .sig_i (sig_q),
    .y_i   (y),
    .sig_o (step_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    // Abort leaves signature, count and pass visible for post-mortem.
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            num_d   = num_vec;
            exp_d   = exp_sig;
            sig_d   = SEED;
            cnt_d   = '0;
            pass_d  = 1'b0;
            state_d = (num_vec == '0) ? ST_CHECK : ST_RUN;
          end
        end
        ST_RUN: begin
          if (y_valid) begin
            sig_d = step_sig;
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == num_q) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          pass_d  = (sig_q == exp_q);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = cnt_q;

endmodule

// File: doc/resp_sig_capture.md
# resp_sig_capture

Synthesizable response compactor for the fuzz-simulation flow: the receiving end of the stimulus-vector interface into `top`. It samples the 245-bit `y` result bus on every valid clock, folds it into a 32-bit MISR signature over a programmed number of vectors, and compares the signature against an expected value. It replaces per-cycle `$strobe` dumps when comparing synthesized netlists against RTL in simulation and on FPGA.

## Interface
- `DATA_W`, 245: width of the response bus `y`.
- `SIG_W`, 32: signature width.
- `POLY`, 32'h04C1_1DB7: MISR feedback polynomial.
- `SEED`, 32'hFFFF_FFFF: signature value loaded on start.
- `CNT_W`, 16: vector counter width.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin capture; sampled only in IDLE.
- `abort`  in  1  return to IDLE without `done`; priority over all other inputs except reset.
- `num_vec`  in  CNT_W  number of vectors to compact; latched on start.
- `exp_sig`  in  SIG_W  expected signature; latched on start.
- `y_valid`  in  1  `y` carries a vector this cycle.
- `y`  in  DATA_W  response bus from `top`.
- `busy`  out  1  high in RUN or CHECK.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  compare result; held until the next accepted start.
- `signature`  out  SIG_W  current MISR value.
- `vec_count`  out  CNT_W  vectors accepted since start.

## Operation
- FSM states are IDLE, RUN and CHECK.
- **IDLE**
  - On `start`: latch `num_vec` and `exp_sig`, load `signature`=SEED, clear `vec_count`, clear `pass`.
  - Then go to CHECK if `num_vec`==0, else to RUN.
- **RUN**
  - Each cycle with `y_valid`=1: `signature`<=step(`signature`,`y`) and `vec_count`++.
  - If that accept makes `vec_count`==`num_vec`, go to CHECK.
  - `y_valid`=0 cycles hold all state; gaps are unlimited.
- **CHECK**
  - One cycle only: `pass`<=(`signature`==latched `exp_sig`), `done`<=1, go to IDLE.
- **Step function**
  - Zero-extend `y` to the next multiple of SIG_W (256 bits).
  - fold = XOR of the 8 SIG_W-bit slices.
  - step = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold.
- `start` while `busy` is ignored.
- `y_valid` outside RUN is ignored; it does not change `signature` or `vec_count`.
- `abort` in any state: go to IDLE, `done`=0, keep `signature`, `vec_count` and `pass`.
- **Reset** (asynchronous, including mid-run):
  - state=IDLE, `signature`=SEED, `vec_count`=0, `done`=0, `pass`=0, `busy`=0.
  - Nothing resumes after reset.
- `vec_count` never wraps: the terminal compare happens at `num_vec` ≤ 2^CNT_W−1.

## Timing
- **Edge E0 accepts `start`.** State changes at E0; the first `y` can be accepted at E1.
- **Edge Ek accepts the last vector.** Then:
  - At Ek, state becomes CHECK and `busy` stays high.
  - At Ek+1, `done`=1, `pass` becomes valid, `busy`=0.
  - At Ek+2, `done`=0.
- **`num_vec`==0:** `done` is high after E1.
- **Latency:** `signature` and `vec_count` reflect an accepted vector one edge after it is presented.
- **Back-to-back runs:** `start` is accepted in the cycle `done` is high, because the FSM is already in IDLE.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- **Package `resp_sig_pkg`:** state enum (IDLE/RUN/CHECK), default POLY and SEED constants, SIG_W default.
- **Sub-module `resp_misr_step`:** combinational fold plus one MISR shift, parameterized on DATA_W, SIG_W and POLY.
  - The top-level block instantiates it once.
  - Benches reuse it to compute golden signatures.
- **Top level:** FSM, counters, latches and the compare.

## Test plan
- **Empty run:** reset, then `start` with `num_vec`=0 and `exp_sig`=32'hFFFF_FFFF -> `done` pulse after E1, `pass`=1, `signature`=32'hFFFF_FFFF, `vec_count`=0.
- **Single zero vector:** `num_vec`=1, `y`=0, `y_valid`=1 -> `signature`=32'hFB3E_E249, `pass`=1 when `exp_sig` matches; with `y`=1 -> `signature`=32'hFB3E_E248, and `exp_sig`=32'hFB3E_E249 gives `pass`=0.
- **Gapped run:** the 21 testbench vectors from the fuzz_968 flow with random `y_valid` gaps -> `signature` and `vec_count`=21 identical to a gap-free run and to the `resp_misr_step` golden model.
- **Abort and ignored start:** `abort` after 5 of 10 vectors -> no `done`, IDLE, `vec_count`=5; `start` issued during RUN -> no effect on counters.
- **Reset mid-run:** assert `rst_n`=0 asynchronously between edges in RUN -> outputs immediately take reset values (`signature`=SEED); a new run afterwards completes normally.
- **Back-to-back:** assert `start` in the `done` cycle -> second run accepts its first vector on the next edge, and `pass` reflects only the second run.
